// File: rtl/example_peripheral_pkg.sv
`default_nettype none
// ============================================================================
// Module      : example_peripheral_pkg
// Description : Shared widths, defaults and config type for the peripheral core.
// Revision    : 1.0 - initial release
// ============================================================================
package example_peripheral_pkg;

    localparam int COUNT_W            = 32;
    localparam int FIFO_DATA_W        = 8;
    localparam int WORD_COUNT_W       = 8;
    localparam int DEFAULT_FIFO_DEPTH = 16;
    localparam logic [COUNT_W-1:0] DEFAULT_LT_THRESHOLD = 32'd1000;

    typedef struct packed {
        logic en;
        logic dir;
        logic ire;
    } cfg_t;

    // True when one more step in direction dir crosses the 0 / all-ones boundary.
    function automatic logic is_wrap_point(input logic [COUNT_W-1:0] value, input logic dir);
        return dir ? (&value) : ~(|value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/example_peripheral_core_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO; drops pushes when
//               full, ignores pops when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == (PTR_W+1)'(DEPTH));
    assign count = r_count;
    assign rdata = empty ? '0 : r_mem[r_rd_ptr];

    // A pop frees the slot that a same-cycle push into a full FIFO needs.
    assign w_do_pop  = re && !empty;
    assign w_do_push = we && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/example_peripheral_core.sv
`default_nettype none
// ============================================================================
// Module      : example_peripheral_core
// Description : Up/down counter with config, lt_1k status, wrap interrupt and
//               an 8-bit FWFT FIFO behind a register decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module example_peripheral_core
    import example_peripheral_pkg::*;
#(
    parameter int                 FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter logic [COUNT_W-1:0] LT_THRESHOLD = DEFAULT_LT_THRESHOLD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    count_we,
    input  logic                    config_we,
    input  logic                    fifo_we,
    input  logic                    fifo_re,
    input  logic [COUNT_W-1:0]      count_in,
    input  logic                    en_in,
    input  logic                    dir_in,
    input  logic                    ire_in,
    input  logic [FIFO_DATA_W-1:0]  fifo_data_in,
    output logic [COUNT_W-1:0]      count_out,
    output logic                    en_out,
    output logic                    dir_out,
    output logic                    ire_out,
    output logic                    lt_1k_out,
    output logic                    fifo_empty,
    output logic                    fifo_full,
    output logic [WORD_COUNT_W-1:0] fifo_word_count,
    output logic [FIFO_DATA_W-1:0]  fifo_data_out,
    output logic                    irq_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    cfg_t               r_cfg;
    logic [COUNT_W-1:0] r_count;
    logic               r_irq;
    logic               w_step;
    logic               w_wrap;
    logic [PTR_W:0]     w_fifo_count;

    assign count_out = r_count;
    assign en_out    = r_cfg.en;
    assign dir_out   = r_cfg.dir;
    assign ire_out   = r_cfg.ire;
    assign irq_out   = r_irq;
    assign lt_1k_out = (r_count < LT_THRESHOLD);

    // Loads take priority over stepping and never count as a wrap.
    assign w_step = r_cfg.en && !count_we;
    assign w_wrap = w_step && is_wrap_point(r_count, r_cfg.dir);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (count_we) begin
            r_count <= count_in;
        end else if (w_step) begin
            r_count <= r_cfg.dir ? (r_count + 32'd1) : (r_count - 32'd1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg <= '0;
        end else if (config_we) begin
            r_cfg <= '{en: en_in, dir: dir_in, ire: ire_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_wrap && r_cfg.ire;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .we    (fifo_we),
        .re    (fifo_re),
        .wdata (fifo_data_in),
        .rdata (fifo_data_out),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (w_fifo_count)
    );

    assign fifo_word_count = WORD_COUNT_W'(w_fifo_count);

endmodule
`default_nettype wire

// File: tb/tb_example_peripheral_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_example_peripheral_core
// Description : Directed, table-driven self-checking bench for the peripheral core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_example_peripheral_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        count_we, config_we, fifo_we, fifo_re;
    logic [31:0] count_in;
    logic        en_in, dir_in, ire_in;
    logic [7:0]  fifo_data_in;
    logic [31:0] count_out;
    logic        en_out, dir_out, ire_out, lt_1k_out;
    logic        fifo_empty, fifo_full;
    logic [7:0]  fifo_word_count, fifo_data_out;
    logic        irq_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    example_peripheral_core dut (
        .clk             (clk),
        .reset           (reset),
        .count_we        (count_we),
        .config_we       (config_we),
        .fifo_we         (fifo_we),
        .fifo_re         (fifo_re),
        .count_in        (count_in),
        .en_in           (en_in),
        .dir_in          (dir_in),
        .ire_in          (ire_in),
        .fifo_data_in    (fifo_data_in),
        .count_out       (count_out),
        .en_out          (en_out),
        .dir_out         (dir_out),
        .ire_out         (ire_out),
        .lt_1k_out       (lt_1k_out),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .fifo_word_count (fifo_word_count),
        .fifo_data_out   (fifo_data_out),
        .irq_out         (irq_out)
    );

    typedef struct {
        logic        cwe;
        logic [31:0] cin;
        logic        gwe;
        logic [2:0]  cfg;   // {en, dir, ire}
        logic [31:0] ecount;
        logic        elt;
        logic        eirq;
        logic [2:0]  ecfg;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_step(input logic we, input logic re, input logic [7:0] d);
        fifo_we      = we;
        fifo_re      = re;
        fifo_data_in = d;
        tick();
        fifo_we = 1'b0;
        fifo_re = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, count_out, 32'd0);
        chk({tag, "_cfg"}, {29'd0, en_out, dir_out, ire_out}, 32'd0);
        chk({tag, "_lt"}, {31'd0, lt_1k_out}, 32'd1);
        chk({tag, "_irq"}, {31'd0, irq_out}, 32'd0);
        chk({tag, "_empty"}, {31'd0, fifo_empty}, 32'd1);
        chk({tag, "_full"}, {31'd0, fifo_full}, 32'd0);
        chk({tag, "_wc"}, {24'd0, fifo_word_count}, 32'd0);
        chk({tag, "_dout"}, {24'd0, fifo_data_out}, 32'd0);
    endtask

    initial begin
        // Counter/config/irq vectors: inputs applied for one edge, outputs checked after it.
        vecs[0]  = '{1'b1, 32'd998,        1'b1, 3'b110, 32'd998,        1'b1, 1'b0, 3'b110};
        vecs[1]  = '{1'b0, 32'd0,          1'b0, 3'b000, 32'd999,        1'b1, 1'b0, 3'b110};
        vecs[2]  = '{1'b0, 32'd0,          1'b0, 3'b000, 32'd1000,       1'b0, 1'b0, 3'b110};
        vecs[3]  = '{1'b1, 32'hFFFF_FFFE,  1'b1, 3'b111, 32'hFFFF_FFFE,  1'b0, 1'b0, 3'b111};
        vecs[4]  = '{1'b0, 32'd0,          1'b0, 3'b000, 32'hFFFF_FFFF,  1'b0, 1'b0, 3'b111};
        vecs[5]  = '{1'b0, 32'd0,          1'b0, 3'b000, 32'h0000_0000,  1'b1, 1'b1, 3'b111};
        vecs[6]  = '{1'b0, 32'd0,          1'b0, 3'b000, 32'h0000_0001,  1'b1, 1'b0, 3'b111};
        vecs[7]  = '{1'b1, 32'hFFFF_FFFE,  1'b1, 3'b110, 32'hFFFF_FFFE,  1'b0, 1'b0, 3'b110};
        vecs[8]  = '{1'b0, 32'd0,          1'b0, 3'b000, 32'hFFFF_FFFF,  1'b0, 1'b0, 3'b110};
        vecs[9]  = '{1'b0, 32'd0,          1'b0, 3'b000, 32'h0000_0000,  1'b1, 1'b0, 3'b110};
        vecs[10] = '{1'b0, 32'd0,          1'b0, 3'b000, 32'h0000_0001,  1'b1, 1'b0, 3'b110};
        vecs[11] = '{1'b1, 32'd0,          1'b1, 3'b101, 32'h0000_0000,  1'b1, 1'b0, 3'b101};
        vecs[12] = '{1'b0, 32'd0,          1'b0, 3'b000, 32'hFFFF_FFFF,  1'b0, 1'b1, 3'b101};
        vecs[13] = '{1'b0, 32'd0,          1'b0, 3'b000, 32'hFFFF_FFFE,  1'b0, 1'b0, 3'b101};
        vecs[14] = '{1'b1, 32'd5,          1'b0, 3'b000, 32'd5,          1'b1, 1'b0, 3'b101};
        vecs[15] = '{1'b0, 32'd0,          1'b0, 3'b000, 32'd4,          1'b1, 1'b0, 3'b101};

        reset = 1'b1;
        count_we = 1'b0; config_we = 1'b0; fifo_we = 1'b0; fifo_re = 1'b0;
        count_in = '0; en_in = 1'b0; dir_in = 1'b0; ire_in = 1'b0; fifo_data_in = '0;
        tick();
        tick();
        chk_reset_state("rst");
        reset = 1'b0;

        // Counter, lt_1k, wrap and irq.
        for (int i = 0; i < 16; i++) begin
            count_we  = vecs[i].cwe;
            count_in  = vecs[i].cin;
            config_we = vecs[i].gwe;
            {en_in, dir_in, ire_in} = vecs[i].cfg;
            tick();
            count_we  = 1'b0;
            config_we = 1'b0;
            chk($sformatf("v%0d_count", i), count_out, vecs[i].ecount);
            chk($sformatf("v%0d_lt", i), {31'd0, lt_1k_out}, {31'd0, vecs[i].elt});
            chk($sformatf("v%0d_irq", i), {31'd0, irq_out}, {31'd0, vecs[i].eirq});
            chk($sformatf("v%0d_cfg", i), {29'd0, en_out, dir_out, ire_out}, {29'd0, vecs[i].ecfg});
        end

        // Freeze the counter during the FIFO checks.
        config_we = 1'b1; {en_in, dir_in, ire_in} = 3'b000;
        tick();
        config_we = 1'b0;

        // Fill, overflow, drain, underflow.
        for (int i = 0; i < 16; i++) begin
            fifo_step(1'b1, 1'b0, 8'(i));
            chk($sformatf("fill%0d_wc", i), {24'd0, fifo_word_count}, 32'(i + 1));
            chk($sformatf("fill%0d_head", i), {24'd0, fifo_data_out}, 32'h00);
        end
        chk("full_flag", {31'd0, fifo_full}, 32'd1);
        fifo_step(1'b1, 1'b0, 8'hAA);
        chk("ovf_wc", {24'd0, fifo_word_count}, 32'd16);
        chk("ovf_full", {31'd0, fifo_full}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_data", i), {24'd0, fifo_data_out}, 32'(i));
            fifo_step(1'b0, 1'b1, 8'h00);
        end
        chk("drain_empty", {31'd0, fifo_empty}, 32'd1);
        chk("drain_dout", {24'd0, fifo_data_out}, 32'd0);
        fifo_step(1'b0, 1'b1, 8'h00);
        chk("udf_wc", {24'd0, fifo_word_count}, 32'd0);
        chk("udf_empty", {31'd0, fifo_empty}, 32'd1);
        chk("udf_full", {31'd0, fifo_full}, 32'd0);

        // Simultaneous push/pop when full: new byte goes to the tail.
        for (int i = 0; i < 16; i++) begin
            fifo_step(1'b1, 1'b0, 8'(8'h10 + i));
        end
        fifo_step(1'b1, 1'b1, 8'h55);
        chk("pp_full_wc", {24'd0, fifo_word_count}, 32'd16);
        chk("pp_full_flag", {31'd0, fifo_full}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pp_drain%0d", i), {24'd0, fifo_data_out},
                (i < 15) ? 32'(8'h11 + i) : 32'h55);
            fifo_step(1'b0, 1'b1, 8'h00);
        end
        chk("pp_drain_empty", {31'd0, fifo_empty}, 32'd1);

        // Simultaneous push/pop when empty: push only.
        fifo_step(1'b1, 1'b1, 8'h66);
        chk("pp_empty_wc", {24'd0, fifo_word_count}, 32'd1);
        chk("pp_empty_dout", {24'd0, fifo_data_out}, 32'h66);
        chk("pp_empty_flag", {31'd0, fifo_empty}, 32'd0);
        fifo_step(1'b0, 1'b1, 8'h00);

        // Asynchronous reset mid-count with 5 FIFO entries.
        count_we = 1'b1; count_in = 32'd100;
        config_we = 1'b1; {en_in, dir_in, ire_in} = 3'b111;
        tick();
        count_we = 1'b0; config_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fifo_step(1'b1, 1'b0, 8'(8'hC0 + i));
        end
        chk("pre_rst_count", count_out, 32'd105);
        chk("pre_rst_wc", {24'd0, fifo_word_count}, 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("async");
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_hold", count_out, 32'd0);
        config_we = 1'b1; {en_in, dir_in, ire_in} = 3'b110;
        tick();
        config_we = 1'b0;
        chk("reen_count0", count_out, 32'd0);
        chk("reen_en", {31'd0, en_out}, 32'd1);
        tick();
        chk("reen_count1", count_out, 32'd1);
        tick();
        chk("reen_count2", count_out, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
